// File: rtl/read_control.sv
// read_control: read-side pointer and empty-flag controller for a dual-clock FIFO.
// Build option READ_CONTROL_LEVEL_EN adds the registered occupancy level and almost-empty flag.
module read_control #(
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                r_req,
  input  logic [ADDR_WIDTH:0] w_g_syn_addr,
  output logic [ADDR_WIDTH:0] r_addr,
  output logic [ADDR_WIDTH:0] r_g_addr,
  output logic                r_empty,
  output logic                r_almost_empty,
  output logic [ADDR_WIDTH:0] r_level
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic          w_rd;
  logic [PW-1:0] w_addr_nxt;
  logic [PW-1:0] w_g_nxt;

  // A request while empty is silently dropped.
  assign w_rd       = r_req & ~r_empty;
  assign w_addr_nxt = r_addr + PW'(w_rd);
  assign w_g_nxt    = w_addr_nxt ^ (w_addr_nxt >> 1);

  // Empty uses the post-read pointer so the last read flags empty on its own edge.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_addr   <= '0;
      r_g_addr <= '0;
      r_empty  <= 1'b1;
    end else begin
      r_addr   <= w_addr_nxt;
      r_g_addr <= w_g_nxt;
      r_empty  <= (w_g_nxt == w_g_syn_addr);
    end
  end

`ifdef READ_CONTROL_LEVEL_EN
  logic [PW-1:0] w_bin;
  logic [PW-1:0] w_level_nxt;

  // Gray-to-binary: each bit is the XOR of itself and every bit above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      w_bin[i] = ^(w_g_syn_addr >> i);
    end
  end

  assign w_level_nxt = w_bin - w_addr_nxt;

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_level        <= '0;
      r_almost_empty <= 1'b1;
    end else begin
      r_level        <= w_level_nxt;
      r_almost_empty <= (w_level_nxt <= PW'(ALMOST_EMPTY_TH));
    end
  end
`else
  assign r_level        = '0;
  assign r_almost_empty = r_empty;
`endif

endmodule

// File: tb/tb_read_control.sv
// Scoreboard bench for read_control: a binary-domain model pushes expectations, a monitor pops and checks them.
module tb_read_control;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TH = 2;

  logic          r_clk = 1'b0;
  logic          r_rst;
  logic          r_req;
  logic [PW-1:0] w_g_syn_addr;
  logic [PW-1:0] r_addr;
  logic [PW-1:0] r_g_addr;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_level;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [PW-1:0] g;
    logic          empty;
    logic          almost;
    logic [PW-1:0] level;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [PW-1:0] m_rd;
  logic [PW-1:0] m_wbin;
  logic          m_empty;

  always #5 r_clk = ~r_clk;

  read_control #(
    .ADDR_WIDTH     (AW),
    .ALMOST_EMPTY_TH(TH)
  ) dut (
    .r_clk         (r_clk),
    .r_rst         (r_rst),
    .r_req         (r_req),
    .w_g_syn_addr  (w_g_syn_addr),
    .r_addr        (r_addr),
    .r_g_addr      (r_g_addr),
    .r_empty       (r_empty),
    .r_almost_empty(r_almost_empty),
    .r_level       (r_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Drive one cycle of stimulus and push the model's post-edge expectation.
  task automatic step(input logic req, input logic [PW-1:0] wbin);
    exp_t          e;
    logic [PW-1:0] lvl;
    @(negedge r_clk);
    r_req        = req;
    w_g_syn_addr = bin2gray(wbin);
    if (req && !m_empty) m_rd = m_rd + 1'b1;
    m_wbin  = wbin;
    m_empty = (m_rd == m_wbin);
    lvl     = m_wbin - m_rd;
    e.addr  = m_rd;
    e.g     = bin2gray(m_rd);
    e.empty = m_empty;
`ifdef READ_CONTROL_LEVEL_EN
    e.level  = lvl;
    e.almost = (lvl <= TH);
`else
    e.level  = '0;
    e.almost = m_empty;
`endif
    exp_q.push_back(e);
    @(posedge r_clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(posedge r_clk);
    #3;
    r_rst = 1'b0;
    #1;
    chk({tag, "_addr"},   r_addr,         0);
    chk({tag, "_gaddr"},  r_g_addr,       0);
    chk({tag, "_empty"},  r_empty,        1);
    chk({tag, "_almost"}, r_almost_empty, 1);
    chk({tag, "_level"},  r_level,        0);
    r_req        = 1'b0;
    w_g_syn_addr = '0;
    m_rd         = '0;
    m_wbin       = '0;
    m_empty      = 1'b1;
    @(negedge r_clk);
    r_rst = 1'b1;
  endtask

  always @(posedge r_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("addr",   r_addr,         e.addr);
      chk("gaddr",  r_g_addr,       e.g);
      chk("empty",  r_empty,        e.empty);
      chk("almost", r_almost_empty, e.almost);
      chk("level",  r_level,        e.level);
    end
  end

  initial begin
    logic [PW-1:0] occ;
    logic [PW-1:0] wb;
    r_rst        = 1'b1;
    r_req        = 1'b0;
    w_g_syn_addr = '0;
    m_rd         = '0;
    m_wbin       = '0;
    m_empty      = 1'b1;

    do_reset("rst0");

    // Fill to 3, drain, then over-read while empty.
    step(1'b0, 5'd3);
    repeat (3) step(1'b1, 5'd3);
    repeat (2) step(1'b1, 5'd3);

    // Full depth, then a second pass to roll the pointer over 31 -> 0.
    do_reset("rst1");
    step(1'b0, 5'd16);
    repeat (16) step(1'b1, 5'd16);
    step(1'b0, 5'd0);
    repeat (16) step(1'b1, 5'd0);

    // Read and write pointer advance on the same edge at level 1.
    step(1'b0, 5'd1);
    step(1'b1, 5'd2);

    // Reset in the middle of a drain at r_addr = 7.
    step(1'b0, 5'd10);
    repeat (6) step(1'b1, 5'd10);
    do_reset("rst2");
    step(1'b1, 5'd0);
    step(1'b1, 5'd4);
    step(1'b1, 5'd4);

    // Random traffic with occupancy bounded by the FIFO depth.
    wb = m_wbin;
    for (int i = 0; i < 300; i++) begin
      occ = m_wbin - m_rd;
      if (occ < 5'd16 && $urandom_range(0, 1) == 1) wb = wb + 1'b1;
      step(1'($urandom_range(0, 1)), wb);
    end

    @(negedge r_clk);
    r_req = 1'b0;
    repeat (2) @(posedge r_clk);
    #2;
    chk("q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/read_control.md
# read_control

Read-side pointer and flag controller for the dual-clock asynchronous FIFO, mirror of the write-side controller. It advances the binary read pointer on accepted read requests and publishes the registered Gray-coded read pointer for synchronization into the write domain. It derives a registered empty flag from the write Gray pointer after that pointer has been synchronized into the read domain. It sits between the read-domain consumer and the FIFO RAM read port; the synchronizer is external.

## Interface
- `ADDR_WIDTH`, default 4: RAM address bits; pointers are `ADDR_WIDTH+1` bits (extra wrap bit); depth = 2^ADDR_WIDTH.
- `ALMOST_EMPTY_TH`, default 2: `r_almost_empty` asserts when occupancy ≤ this value.
- `r_clk`, input, 1: read-domain clock; all state on rising edge.
- `r_rst`, input, 1: asynchronous, active-low reset.
- `r_req`, input, 1: read request; accepted only when `r_empty`=0.
- `w_g_syn_addr`, input, `ADDR_WIDTH+1`: write Gray pointer, already synchronized into `r_clk`.
- `r_addr`, output, `ADDR_WIDTH+1`: binary read pointer (registered); RAM uses `r_addr[ADDR_WIDTH-1:0]`.
- `r_g_addr`, output, `ADDR_WIDTH+1`: Gray read pointer (registered, glitch-free, for CDC).
- `r_empty`, output, 1: registered empty flag.
- `r_almost_empty`, output, 1: registered, occupancy ≤ `ALMOST_EMPTY_TH`.
- `r_level`, output, `ADDR_WIDTH+1`: registered occupancy, 0..2^ADDR_WIDTH.

## Operation
- Accept condition: `r_rd = r_req & ~r_empty`.
- Next binary pointer: `r_addr_nxt = r_addr + r_rd`, modulo 2^(ADDR_WIDTH+1).
- Next Gray pointer: `r_g_nxt = r_addr_nxt ^ (r_addr_nxt >> 1)`.
- `r_addr` and `r_g_addr` register `r_addr_nxt` and `r_g_nxt`. `r_g_addr` must never be driven combinationally.
- Empty: `r_empty <= (r_g_nxt == w_g_syn_addr)`. This is a full-width Gray compare, including the MSB.
- Level: convert `w_g_syn_addr` to binary with an XOR prefix from the MSB down. Then `r_level <= w_bin - r_addr_nxt`, modulo 2^(ADDR_WIDTH+1).
- `r_almost_empty <= (level_nxt <= ALMOST_EMPTY_TH)`.
- A read request while empty is ignored: the pointer holds and no error is flagged.
- Wrap: the pointer rolls from 2^(ADDR_WIDTH+1)-1 to 0. The Gray MSB toggles each pass through the RAM.
- Occupancy 2^ADDR_WIDTH (FIFO full as seen from read side) yields `r_level` = 2^ADDR_WIDTH (MSB set, low bits 0).
- Reset, asynchronous, mid-operation: all state clears immediately. Upstream is responsible for resetting both domains together.

## Timing
- Reset values: `r_addr`=0, `r_g_addr`=0, `r_empty`=1, `r_almost_empty`=1, `r_level`=0.
- Pointer, empty, level and almost-empty all update on the same edge that accepts a read. The read that consumes the last word sets `r_empty`=1 on that edge, so there is no extra-read window.
- A change on `w_g_syn_addr` is reflected in the flags and level one `r_clk` edge later.
- Empty deassertion is pessimistic by the external sync latency, which is safe.
- Simultaneous read accept and `w_g_syn_addr` advance are both applied in the same update.
- RAM data for `r_addr[ADDR_WIDTH-1:0]` is valid per the RAM's own read latency; this block does not register data.

## Configuration
- `READ_CONTROL_LEVEL_EN` defined: Gray-to-binary converter and the `r_level`/`r_almost_empty` registers are compiled in as above.
- Not defined: converter and registers are omitted. `r_level` is tied to 0 and `r_almost_empty` is driven from `r_empty`. Pointer and empty behaviour is identical in both builds.

## Test plan
ADDR_WIDTH=4, ALMOST_EMPTY_TH=2, macro defined unless stated.
- **Reset:** assert `r_rst`=0 mid-clock. Required: immediately `r_addr`=0, `r_g_addr`=0, `r_empty`=1, `r_almost_empty`=1, `r_level`=0.
- **Basic fill and drain:** drive `w_g_syn_addr`=5'b00010 (bin 3).
  - After 1 edge: `r_empty`=0, `r_level`=3, `r_almost_empty`=0.
  - Hold `r_req`=1: `r_addr` steps 1,2,3 with `r_level` 2,1,0. `r_almost_empty`=1 from the first read; `r_empty`=1 on the third edge.
  - Further `r_req` leaves `r_addr`=3.
- **Full-depth wrap:** with `r_addr`=0 set `w_g_syn_addr`=5'b11000 (bin 16). Required: `r_level`=16. Read 16 → `r_addr`=5'b10000, `r_g_addr`=5'b11000, `r_empty`=1. Repeat to verify rollover 31→0 with the Gray MSB returning to 0.
- **Simultaneous events:** at `r_level`=1, same edge read accepted and write pointer +1. Required: `r_level`=1, `r_empty`=0.
- **Reset mid-drain:** at `r_addr`=7, pulse `r_rst` low. Required: all outputs return to reset values asynchronously; the next read is ignored until `w_g_syn_addr` is non-zero.
- **Macro undefined:** rerun the fill-and-drain scenario. Required: `r_level`=0 throughout, `r_almost_empty` equals `r_empty`, and pointer/empty behaviour is unchanged.
